branch_resolver: RTL and testbench

//  Consumer of the comparator flags (lt/gt/equal). Latches them into a flag register
//  on cmp_valid. Accepts one conditional-branch request at a time over a valid/ready

---
 rtl/branch_resolver_if.sv | 26 ++
 rtl/branch_resolver.sv | 166 ++++++++++++++++
 tb/tb_branch_resolver.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolver_if.sv
// Handshake bundle between fetch and the branch resolver: request channel in, result channel out.
interface branch_resolver_if #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 8
);
  logic              br_valid;
  logic              br_ready;
  logic [2:0]        br_cond;
  logic [ADDR_W-1:0] br_pc;
  logic [OFF_W-1:0]  br_offset;

  logic              res_valid;
  logic              res_ready;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;

  modport slave (
    input  br_valid, br_cond, br_pc, br_offset, res_ready,
    output br_ready, res_valid, res_taken, res_target
  );

  modport master (
    output br_valid, br_cond, br_pc, br_offset, res_ready,
    input  br_ready, res_valid, res_taken, res_target
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: stores comparator flags and resolves one conditional branch at a time,
// returning taken/not-taken and the next fetch PC.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | ready for a branch request; latches cond/pc/offset on br_valid
// ST_EVAL    | evaluates the condition against the stored flags
// ST_WAIT    | condition needs flags but none captured yet; waits for cmp_valid
// ST_RESULT  | presents taken/target until fetch accepts it
module branch_resolver #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cmp_valid_i,
  input  logic               lt_i,
  input  logic               gt_i,
  input  logic               equal_i,
  branch_resolver_if.slave   bus,
  output logic               flags_valid_o,
  output logic               flag_err_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EVAL   = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  localparam logic [2:0] CC_EQ     = 3'b000;
  localparam logic [2:0] CC_NE     = 3'b001;
  localparam logic [2:0] CC_LT     = 3'b010;
  localparam logic [2:0] CC_GT     = 3'b011;
  localparam logic [2:0] CC_LE     = 3'b100;
  localparam logic [2:0] CC_GE     = 3'b101;
  localparam logic [2:0] CC_ALWAYS = 3'b110;

  logic [1:0]        state_q,  state_d;
  logic [2:0]        cond_q,   cond_d;
  logic [ADDR_W-1:0] pc_q,     pc_d;
  logic [OFF_W-1:0]  off_q,    off_d;
  logic              taken_q,  taken_d;
  logic [ADDR_W-1:0] target_q, target_d;

  logic [2:0]        flags_q;
  logic              flags_valid_q;
  logic              flag_err_q;

  logic [2:0]        cap_flags;
  logic              cap_onehot;
  logic              flag_lt, flag_gt, flag_eq;
  logic              needs_flags;
  logic              cond_true;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] offset_sext;
  logic [ADDR_W-1:0] taken_target;

  assign cap_flags  = {lt_i, gt_i, equal_i};
  assign cap_onehot = (cap_flags == 3'b100) || (cap_flags == 3'b010) || (cap_flags == 3'b001);

  // Flags are captured in every state; a capture on the accept edge feeds the following EVAL.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flags_q       <= 3'b000;
      flags_valid_q <= 1'b0;
      flag_err_q    <= 1'b0;
    end else begin
      flag_err_q <= cmp_valid_i && !cap_onehot;
      if (cmp_valid_i) begin
        flags_q       <= cap_flags;
        flags_valid_q <= 1'b1;
      end
    end
  end

  assign flag_lt = flags_q[2];
  assign flag_gt = flags_q[1];
  assign flag_eq = flags_q[0];

  // ALWAYS and NEVER are the only codes with both upper bits set.
  assign needs_flags = (cond_q[2:1] != 2'b11);

  always_comb begin
    cond_true = 1'b0;
    case (cond_q)
      CC_EQ:     cond_true = flag_eq;
      CC_NE:     cond_true = !flag_eq;
      CC_LT:     cond_true = flag_lt;
      CC_GT:     cond_true = flag_gt;
      CC_LE:     cond_true = flag_lt || flag_eq;
      CC_GE:     cond_true = flag_gt || flag_eq;
      CC_ALWAYS: cond_true = 1'b1;
      default:   cond_true = 1'b0;
    endcase
  end

  assign pc_plus1     = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign offset_sext  = {{(ADDR_W-OFF_W){off_q[OFF_W-1]}}, off_q};
  assign taken_target = pc_plus1 + offset_sext;

  always_comb begin
    state_d  = state_q;
    cond_d   = cond_q;
    pc_d     = pc_q;
    off_d    = off_q;
    taken_d  = taken_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.br_valid) begin
          cond_d  = bus.br_cond;
          pc_d    = bus.br_pc;
          off_d   = bus.br_offset;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (needs_flags && !flags_valid_q) begin
          state_d = ST_WAIT;
        end else begin
          taken_d  = cond_true;
          target_d = cond_true ? taken_target : pc_plus1;
          state_d  = ST_RESULT;
        end
      end
      ST_WAIT: begin
        // A capture on this edge is already visible to the EVAL that follows.
        if (cmp_valid_i || flags_valid_q) begin
          state_d = ST_EVAL;
        end
      end
      ST_RESULT: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cond_q   <= 3'b000;
      pc_q     <= '0;
      off_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cond_q   <= cond_d;
      pc_q     <= pc_d;
      off_q    <= off_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  assign bus.br_ready   = (state_q == ST_IDLE);
  assign bus.res_valid  = (state_q == ST_RESULT);
  assign bus.res_taken  = taken_q;
  assign bus.res_target = target_q;
  assign flags_valid_o  = flags_valid_q;
  assign flag_err_o     = flag_err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Randomised and directed bench for branch_resolver with a queue scoreboard and a reference model.
module tb_branch_resolver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic cmp_valid = 1'b0, lt = 1'b0, gt = 1'b0, eq = 1'b0;
  logic flags_valid, flag_err;

  branch_resolver_if #(.ADDR_W(16), .OFF_W(8)) bus ();

  branch_resolver #(.ADDR_W(16), .OFF_W(8)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .cmp_valid_i   (cmp_valid),
    .lt_i          (lt),
    .gt_i          (gt),
    .equal_i       (eq),
    .bus           (bus.slave),
    .flags_valid_o (flags_valid),
    .flag_err_o    (flag_err)
  );

  typedef struct {
    logic        taken;
    logic [15:0] target;
    int          edge_n;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;

  // reference model state
  logic [2:0]  mflags  = 3'b000;
  bit          mfv     = 0;
  bit          exp_err = 0;
  bit          last_c  = 0;
  bit          pending = 0;
  logic [2:0]  p_cond;
  logic [15:0] p_pc;
  logic [7:0]  p_off;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_holds(input logic [2:0] cc, input logic [2:0] f);
    bit is_lt, is_gt, is_eq;
    is_lt = f[2]; is_gt = f[1]; is_eq = f[0];
    case (cc)
      3'd0:    return is_eq;
      3'd1:    return !is_eq;
      3'd2:    return is_lt;
      3'd3:    return is_gt;
      3'd4:    return is_lt || is_eq;
      3'd5:    return is_gt || is_eq;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] next_pc(input logic [15:0] pc, input logic [7:0] off, input bit taken);
    int s, t;
    s = int'(off);
    if (s >= 128) s = s - 256;
    t = int'(pc) + 1 + (taken ? s : 0);
    t = ((t % 65536) + 65536) % 65536;
    return t[15:0];
  endfunction

  function automatic exp_t make_exp(input logic [2:0] cc, input logic [15:0] pc, input logic [7:0] off,
                                    input logic [2:0] f, input int edge_n, input bit lat);
    exp_t e;
    e.taken  = cond_holds(cc, f);
    e.target = next_pc(pc, off, e.taken);
    e.edge_n = edge_n;
    e.lat    = lat;
    return e;
  endfunction

  // One clock cycle: drive after the edge, then at the falling edge check flag outputs
  // and advance the model to what the next rising edge will do.
  task automatic step(input logic c, input logic [2:0] f, input logic bv, input logic [2:0] cc,
                      input logic [15:0] pc, input logic [7:0] off, input logic rr, output bit acc);
    @(posedge clk); #1;
    cmp_valid = c; lt = f[2]; gt = f[1]; eq = f[0];
    bus.br_valid = bv; bus.br_cond = cc; bus.br_pc = pc; bus.br_offset = off;
    bus.res_ready = rr;
    @(negedge clk);
    chk("flag_err", flag_err, exp_err);
    chk("flags_valid", flags_valid, mfv);
    acc = bv && (bus.br_ready === 1'b1);
    exp_err = c && !(f == 3'b100 || f == 3'b010 || f == 3'b001);
    last_c  = c;
    if (c) begin
      mflags = f;
      mfv    = 1;
      if (pending) begin
        q.push_back(make_exp(p_cond, p_pc, p_off, mflags, 0, 0));
        pending = 0;
      end
    end
    if (acc) begin
      if (cc[2:1] != 2'b11 && !mfv) begin
        pending = 1; p_cond = cc; p_pc = pc; p_off = off;
      end else begin
        q.push_back(make_exp(cc, pc, off, mflags, cyc + 1, 1));
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0, 3'b000, 16'h0, 8'h0, 1'b1, a);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    cmp_valid = 1'b0; bus.br_valid = 1'b0; bus.res_ready = 1'b0;
    #1;
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_taken", bus.res_taken, 1'b0);
    chk("rst_res_target", bus.res_target, 16'h0);
    chk("rst_flags_valid", flags_valid, 1'b0);
    chk("rst_flag_err", flag_err, 1'b0);
    repeat (2) @(negedge clk);
    q.delete();
    pending = 0; mfv = 0; mflags = 3'b000; exp_err = 0; last_c = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("rst_br_ready", bus.br_ready, 1'b1);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a result
  exp_t cur;
  bit   have_cur = 0;
  bit   after_hs = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_cur = 0;
      after_hs = 0;
    end else begin
      if (after_hs) begin
        chk("post_hs_br_ready", bus.br_ready, 1'b1);
        chk("post_hs_res_valid", bus.res_valid, 1'b0);
        after_hs = 0;
      end
      if (bus.res_valid === 1'b1) begin
        if (!have_cur) begin
          ntests++;
          if (q.size() == 0) begin
            nfail++;
            $display("FAIL sb_underflow: result presented with nothing expected (t=%0t)", $time);
          end else begin
            cur = q.pop_front();
            have_cur = 1;
            if (cur.lat) chk("latency", cyc - cur.edge_n, 1);
          end
        end
        if (have_cur) begin
          chk("res_taken", bus.res_taken, cur.taken);
          chk("res_target", bus.res_target, cur.target);
          chk("busy_br_ready", bus.br_ready, 1'b0);
          if (bus.res_ready === 1'b1) begin
            have_cur = 0;
            after_hs = 1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    bit have_req;
    logic [2:0]  rc, rf;
    logic [15:0] rpc;
    logic [7:0]  roff;
    logic        c;

    bus.br_valid = 1'b0; bus.br_cond = 3'b000; bus.br_pc = 16'h0; bus.br_offset = 8'h0;
    bus.res_ready = 1'b0;
    do_reset();

    // compare lt then EQ branch -> not taken
    step(1'b1, 3'b100, 1'b0, 3'b000, 16'h0000, 8'h00, 1'b1, a);
    step(1'b0, 3'b000, 1'b1, 3'b000, 16'h0010, 8'h05, 1'b1, a);
    chk("t1_accept", a, 1'b1);
    idle(4);

    // eq captured on the same edge the EQ branch is accepted
    step(1'b1, 3'b001, 1'b1, 3'b000, 16'h0100, 8'hFE, 1'b1, a);
    chk("t2_accept", a, 1'b1);
    idle(4);

    // LT with no flags after reset waits for the compare
    do_reset();
    step(1'b0, 3'b000, 1'b1, 3'b010, 16'h0200, 8'h10, 1'b1, a);
    step(1'b0, 3'b000, 1'b0, 3'b000, 16'h0, 8'h0, 1'b1, a);
    chk("t3_br_ready_eval", bus.br_ready, 1'b0);
    step(1'b0, 3'b000, 1'b0, 3'b000, 16'h0, 8'h0, 1'b1, a);
    chk("t3_br_ready_wait", bus.br_ready, 1'b0);
    chk("t3_no_result", bus.res_valid, 1'b0);
    step(1'b1, 3'b010, 1'b0, 3'b000, 16'h0, 8'h0, 1'b1, a);
    idle(4);

    // ALWAYS needs no flags, target wraps
    do_reset();
    step(1'b0, 3'b000, 1'b1, 3'b110, 16'hFFFF, 8'h01, 1'b1, a);
    idle(4);

    // back-pressure: result held while res_ready is low
    step(1'b1, 3'b001, 1'b0, 3'b000, 16'h0, 8'h0, 1'b1, a);
    step(1'b0, 3'b000, 1'b1, 3'b101, 16'h1234, 8'h80, 1'b0, a);
    for (int i = 0; i < 5; i++) step(1'b0, 3'b000, 1'b0, 3'b000, 16'h0, 8'h0, 1'b0, a);
    chk("t5_held_valid", bus.res_valid, 1'b1);
    idle(3);

    // non-one-hot capture, then reset while waiting for flags
    step(1'b1, 3'b110, 1'b0, 3'b000, 16'h0, 8'h0, 1'b1, a);
    idle(3);
    do_reset();
    step(1'b0, 3'b000, 1'b1, 3'b010, 16'h0300, 8'h01, 1'b1, a);
    idle(2);
    chk("t6_waiting", bus.br_ready, 1'b0);
    do_reset();
    idle(2);

    // randomised traffic
    have_req = 0;
    for (int i = 0; i < 1200; i++) begin
      if (!have_req && $urandom_range(0, 2) == 0) begin
        have_req = 1;
        rc   = 3'($urandom_range(0, 7));
        rpc  = 16'($urandom);
        roff = 8'($urandom);
      end
      c  = !last_c && ($urandom_range(0, 3) == 0);
      rf = 3'($urandom_range(0, 7));
      step(c, rf, have_req, rc, rpc, roff, $urandom_range(0, 3) != 0, a);
      if (a) have_req = 0;
    end

    idle(1);
    step(1'b1, 3'b100, 1'b0, 3'b000, 16'h0, 8'h0, 1'b1, a);
    idle(10);
    chk("sb_empty", q.size(), 0);
    chk("no_pending", pending, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
